// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, MEM latch layout and MMIO/canary constants for the writeback stage
package wb_stage_pkg;
    localparam int DBITS      = 32;
    localparam int REGNOBITS  = 5;
    localparam int NREGS      = 1 << REGNOBITS;
    localparam int CANARYBITS = 32;
    localparam int HEXBITS    = 24;
    localparam int LEDRBITS   = 10;

    localparam logic [DBITS-1:0]      ADDRHEX          = 32'hFFFF_F000;
    localparam logic [DBITS-1:0]      ADDRLEDR         = 32'hFFFF_F020;
    localparam logic [CANARYBITS-1:0] BUS_CANARY_VALUE = 32'hC0DE_CAFE;

    // Field order is MSB-first and fixes the packing of the MEM latch bus.
    typedef struct packed {
        logic [DBITS-1:0]      inst;
        logic [DBITS-1:0]      pc;
        logic [DBITS-1:0]      memaddr;
        logic [DBITS-1:0]      regval;
        logic [DBITS-1:0]      regval2;
        logic                  wr_mem;
        logic                  wr_reg;
        logic [REGNOBITS-1:0]  wregno;
        logic                  valid;
        logic [CANARYBITS-1:0] bus_canary;
    } mem_latch_t;

    localparam int MEM_latch_WIDTH  = $bits(mem_latch_t);
    localparam int WB_TO_DE_WIDTH   = 1 + REGNOBITS + DBITS;
    localparam int WB_TO_AGEX_WIDTH = WB_TO_DE_WIDTH;
    localparam int WB_TO_MEM_WIDTH  = 1;
endpackage

// File: rtl/wb_stage_regfile_2r1w.sv
// rtl/wb_stage_regfile_2r1w.sv - 32x32 register file, two async read ports with write-through, one sync write port
module regfile_2r1w
    import wb_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [REGNOBITS-1:0] i_waddr,
    input  logic [DBITS-1:0]     i_wdata,
    input  logic [REGNOBITS-1:0] i_raddr1,
    input  logic [REGNOBITS-1:0] i_raddr2,
    output logic [DBITS-1:0]     o_rdata1,
    output logic [DBITS-1:0]     o_rdata2
);
    logic [DBITS-1:0] r_regs [NREGS];
    logic [DBITS-1:0] w_rdata1;
    logic [DBITS-1:0] w_rdata2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Entry 0 is never written; the read mux forces x0 to zero regardless.
    always_comb begin
        w_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            w_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            w_rdata1 = i_wdata;
        end
    end

    always_comb begin
        w_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            w_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            w_rdata2 = i_wdata;
        end
    end

    assign o_rdata1 = w_rdata1;
    assign o_rdata2 = w_rdata2;
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: register commit, HEX/LEDR outputs, retire counter and sticky canary flag
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MEM_latch_WIDTH-1:0]  from_MEM_latch,
    input  logic [REGNOBITS-1:0]        rs1_DE,
    input  logic [REGNOBITS-1:0]        rs2_DE,
    output logic [DBITS-1:0]            rs1_val_WB,
    output logic [DBITS-1:0]            rs2_val_WB,
    output logic [WB_TO_DE_WIDTH-1:0]   from_WB_to_DE,
    output logic [WB_TO_AGEX_WIDTH-1:0] from_WB_to_AGEX,
    output logic [WB_TO_MEM_WIDTH-1:0]  from_WB_to_MEM,
    output logic [HEXBITS-1:0]          HEX,
    output logic [LEDRBITS-1:0]         LEDR,
    output logic [DBITS-1:0]            retired_cnt,
    output logic                        canary_err
);
    mem_latch_t            w_mem;
    logic                  w_commit;
    logic                  w_canary_bad;
    logic                  w_unused;
    logic [HEXBITS-1:0]    r_hex;
    logic [LEDRBITS-1:0]   r_ledr;
    logic [DBITS-1:0]      r_retired_cnt;
    logic                  r_canary_err;

    assign w_mem    = from_MEM_latch;
    assign w_unused = ^{w_mem.inst, w_mem.pc, w_mem.regval2[DBITS-1:HEXBITS]};

    // Reset suppresses the commit so a discarded instruction is invisible to forwarding too.
    assign w_commit     = w_mem.valid && w_mem.wr_reg && (w_mem.wregno != '0) && !reset;
    assign w_canary_bad = w_mem.valid && (w_mem.bus_canary != BUS_CANARY_VALUE);

    regfile_2r1w u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_commit),
        .i_waddr  (w_mem.wregno),
        .i_wdata  (w_mem.regval),
        .i_raddr1 (rs1_DE),
        .i_raddr2 (rs2_DE),
        .o_rdata1 (rs1_val_WB),
        .o_rdata2 (rs2_val_WB)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex         <= '0;
            r_ledr        <= '0;
            r_retired_cnt <= '0;
            r_canary_err  <= 1'b0;
        end else if (w_mem.valid) begin
            if (w_mem.wr_mem && (w_mem.memaddr == ADDRHEX)) begin
                r_hex <= w_mem.regval2[HEXBITS-1:0];
            end
            if (w_mem.wr_mem && (w_mem.memaddr == ADDRLEDR)) begin
                r_ledr <= w_mem.regval2[LEDRBITS-1:0];
            end
            r_retired_cnt <= r_retired_cnt + 1'b1;
            if (w_canary_bad) begin
                r_canary_err <= 1'b1;
            end
        end
    end

    assign from_WB_to_DE   = {w_commit, w_mem.wregno, w_mem.regval};
    assign from_WB_to_AGEX = {w_commit, w_mem.wregno, w_mem.regval};
    assign from_WB_to_MEM  = r_canary_err;
    assign HEX             = r_hex;
    assign LEDR            = r_ledr;
    assign retired_cnt     = r_retired_cnt;
    assign canary_err      = r_canary_err;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a model-fed expected-state queue
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct packed {
        logic [23:0] hex;
        logic [9:0]  ledr;
        logic [31:0] cnt;
        logic        cerr;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [MEM_latch_WIDTH-1:0]  from_MEM_latch = '0;
    logic [4:0]                  rs1_DE = '0;
    logic [4:0]                  rs2_DE = '0;
    logic [31:0]                 rs1_val_WB;
    logic [31:0]                 rs2_val_WB;
    logic [WB_TO_DE_WIDTH-1:0]   from_WB_to_DE;
    logic [WB_TO_AGEX_WIDTH-1:0] from_WB_to_AGEX;
    logic [WB_TO_MEM_WIDTH-1:0]  from_WB_to_MEM;
    logic [23:0]                 HEX;
    logic [9:0]                  LEDR;
    logic [31:0]                 retired_cnt;
    logic                        canary_err;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        e;
    exp_t        obs;
    logic [31:0] m_regs [32];
    logic [23:0] m_hex;
    logic [9:0]  m_ledr;
    logic [31:0] m_cnt;
    logic        m_cerr;
    logic [37:0] m_fwd;
    mem_latch_t  lat;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk             (clk),
        .reset           (reset),
        .from_MEM_latch  (from_MEM_latch),
        .rs1_DE          (rs1_DE),
        .rs2_DE          (rs2_DE),
        .rs1_val_WB      (rs1_val_WB),
        .rs2_val_WB      (rs2_val_WB),
        .from_WB_to_DE   (from_WB_to_DE),
        .from_WB_to_AGEX (from_WB_to_AGEX),
        .from_WB_to_MEM  (from_WB_to_MEM),
        .HEX             (HEX),
        .LEDR            (LEDR),
        .retired_cnt     (retired_cnt),
        .canary_err      (canary_err)
    );

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_hex  = '0;
        m_ledr = '0;
        m_cnt  = '0;
        m_cerr = 1'b0;
    endfunction

    // Drives one latch at the falling edge, updates the model and queues the post-edge state.
    task automatic drive(input logic v, input logic wr_reg, input logic wr_mem,
                         input logic [4:0] wregno, input logic [31:0] regval,
                         input logic [31:0] regval2, input logic [31:0] memaddr,
                         input logic [31:0] canary, input logic [4:0] rs1, input logic [4:0] rs2);
        logic commit;
        @(negedge clk);
        reset          = 1'b0;
        lat            = '0;
        lat.inst       = $urandom;
        lat.pc         = $urandom;
        lat.memaddr    = memaddr;
        lat.regval     = regval;
        lat.regval2    = regval2;
        lat.wr_mem     = wr_mem;
        lat.wr_reg     = wr_reg;
        lat.wregno     = wregno;
        lat.valid      = v;
        lat.bus_canary = canary;
        from_MEM_latch = lat;
        rs1_DE         = rs1;
        rs2_DE         = rs2;
        commit = v && wr_reg && (wregno != 5'd0);
        m_fwd  = {commit, wregno, regval};
        if (commit) m_regs[wregno] = regval;
        if (v) begin
            if (wr_mem && memaddr == ADDRHEX)  m_hex  = regval2[23:0];
            if (wr_mem && memaddr == ADDRLEDR) m_ledr = regval2[9:0];
            m_cnt = m_cnt + 32'd1;
            if (canary != BUS_CANARY_VALUE) m_cerr = 1'b1;
        end
        exp_q.push_back({m_hex, m_ledr, m_cnt, m_cerr});
        #1;
    endtask

    task automatic assert_reset(input logic [4:0] wregno, input logic [31:0] regval,
                                input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        reset          = 1'b1;
        lat            = '0;
        lat.valid      = 1'b1;
        lat.wr_reg     = 1'b1;
        lat.wr_mem     = 1'b1;
        lat.memaddr    = ADDRHEX;
        lat.regval2    = 32'h0000_0777;
        lat.wregno     = wregno;
        lat.regval     = regval;
        lat.bus_canary = ~BUS_CANARY_VALUE;
        from_MEM_latch = lat;
        rs1_DE         = rs1;
        rs2_DE         = rs2;
        m_fwd          = {1'b0, wregno, regval};
        exp_q.push_back('0);
        #1;
    endtask

    task automatic test_reset();
        assert_reset(5'd0, 32'h0, 5'd5, 5'd31);
        model_clear();
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, e); end
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd5, 5'd31);
        checks++;
        if ({rs1_val_WB, rs2_val_WB} !== 64'h0) begin
            errors++; $display("FAIL reset_regs: got %h %h expected 0 0", rs1_val_WB, rs2_val_WB);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_bubble: got %h expected %h", obs, e); end
    endtask

    task automatic test_write_through();
        drive(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd5, 5'd3);
        checks++;
        if (rs1_val_WB !== 32'h0000_1234) begin
            errors++; $display("FAIL wt_comb: got %h expected %h", rs1_val_WB, 32'h1234);
        end
        checks++;
        if (from_WB_to_DE !== m_fwd || from_WB_to_AGEX !== m_fwd) begin
            errors++; $display("FAIL wt_fwd: got %h/%h expected %h", from_WB_to_DE, from_WB_to_AGEX, m_fwd);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL wt_state: got %h expected %h", obs, e); end
        drive(1, 1, 0, 5'd9, 32'hCAFE_0009, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd9, 5'd9);
        checks++;
        if ({rs1_val_WB, rs2_val_WB} !== {m_regs[9], m_regs[9]}) begin
            errors++; $display("FAIL wt_both: got %h %h expected %h", rs1_val_WB, rs2_val_WB, m_regs[9]);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        drive(0, 1, 0, 5'd5, 32'hFFFF_FFFF, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd5, 5'd9);
        checks++;
        if ({rs1_val_WB, rs2_val_WB} !== {m_regs[5], m_regs[9]}) begin
            errors++; $display("FAIL wt_array: got %h %h expected %h %h", rs1_val_WB, rs2_val_WB, m_regs[5], m_regs[9]);
        end
        checks++;
        if (from_WB_to_DE[37] !== 1'b0) begin
            errors++; $display("FAIL wt_bubble_fwd: got %b expected 0", from_WB_to_DE[37]);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL wt_bubble_state: got %h expected %h", obs, e); end
    endtask

    task automatic test_x0();
        drive(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd5, 5'd0);
        checks++;
        if (rs2_val_WB !== 32'h0 || from_WB_to_DE[37] !== 1'b0) begin
            errors++; $display("FAIL x0_comb: got %h wr=%b expected 0 wr=0", rs2_val_WB, from_WB_to_DE[37]);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd0, 5'd0);
        checks++;
        if ({rs1_val_WB, rs2_val_WB} !== 64'h0) begin
            errors++; $display("FAIL x0_array: got %h %h expected 0 0", rs1_val_WB, rs2_val_WB);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL x0_state: got %h expected %h", obs, e); end
    endtask

    task automatic test_mmio();
        logic [31:0] addrs [4];
        logic [31:0] vals [4];
        addrs = '{ADDRHEX, ADDRLEDR, 32'h0000_0100, ADDRHEX};
        vals  = '{32'h00AB_CDEF, 32'h0000_03FF, 32'h0012_3456, 32'h0765_4321};
        for (int i = 0; i < 4; i++) begin
            // The last store also writes x14 in the same instruction.
            drive(1, (i == 3), 1, 5'd14, 32'h0000_0E0E, vals[i], addrs[i], BUS_CANARY_VALUE, 5'd14, 5'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
            if (obs !== e) begin errors++; $display("FAIL mmio_%0d: got %h expected %h", i, obs, e); end
        end
        drive(0, 1, 1, 5'd14, 32'h1, 32'h0, ADDRHEX, BUS_CANARY_VALUE, 5'd14, 5'd0);
        checks++;
        if (rs1_val_WB !== 32'h0000_0E0E) begin
            errors++; $display("FAIL mmio_regwrite: got %h expected %h", rs1_val_WB, 32'h0E0E);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL mmio_bubble: got %h expected %h", obs, e); end
    endtask

    task automatic test_counter_wrap();
        logic v_seq [4];
        v_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
        force dut.r_retired_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_retired_cnt;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            // The wrapping instruction also carries a corrupted canary.
            drive(v_seq[i], 0, 0, 5'd0, 32'h0, 32'h0, 32'h0,
                  (i == 1) ? 32'h0BAD_0BAD : BUS_CANARY_VALUE, 5'd0, 5'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
            if (obs !== e) begin errors++; $display("FAIL wrap_%0d: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_canary();
        drive(1, 1, 0, 5'd12, 32'h0000_A5A5, 32'h0, 32'h0, ~BUS_CANARY_VALUE, 5'd12, 5'd0);
        checks++;
        if (rs1_val_WB !== 32'h0000_A5A5) begin
            errors++; $display("FAIL canary_comb: got %h expected %h", rs1_val_WB, 32'hA5A5);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e) begin errors++; $display("FAIL canary_state: got %h expected %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd12, 5'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
            if (obs !== e || from_WB_to_MEM !== 1'b1) begin
                errors++; $display("FAIL canary_sticky_%0d: got %h mem=%b expected %h mem=1", i, obs, from_WB_to_MEM, e);
            end
        end
        checks++;
        if (rs1_val_WB !== 32'h0000_A5A5) begin
            errors++; $display("FAIL canary_write_landed: got %h expected %h", rs1_val_WB, 32'hA5A5);
        end
    endtask

    task automatic test_reset_mid();
        assert_reset(5'd7, 32'h0000_0055, 5'd7, 5'd5);
        checks++;
        if (rs2_val_WB !== 32'h0000_1234 || from_WB_to_DE !== m_fwd) begin
            errors++; $display("FAIL rstmid_comb: got %h fwd=%h expected %h fwd=%h", rs2_val_WB, from_WB_to_DE, 32'h1234, m_fwd);
        end
        model_clear();
        @(posedge clk); #1;
        e = exp_q.pop_front(); obs = {HEX, LEDR, retired_cnt, canary_err}; checks++;
        if (obs !== e || from_WB_to_MEM !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got %h mem=%b expected %h mem=0", obs, from_WB_to_MEM, e);
        end
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, BUS_CANARY_VALUE, 5'd7, 5'd5);
        checks++;
        if ({rs1_val_WB, rs2_val_WB} !== 64'h0) begin
            errors++; $display("FAIL rstmid_regs: got %h %h expected 0 0", rs1_val_WB, rs2_val_WB);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_write_through();
        test_x0();
        test_mmio();
        test_counter_wrap();
        test_canary();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
